// File: rtl/modecount_pkg.sv
// Shared constants for the mode counter, its receive-side monitor and benches.
package modecount_pkg;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_ROTL = 2'b10;
    localparam logic [1:0] MODE_ROTR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACQ   = 2'b01,
        ST_TRACK = 2'b10
    } mon_state_e;

    // Index of the set bit of a one-hot mode mask, i.e. the mode it stands for.
    function automatic logic [1:0] mask_to_mode(input logic [3:0] mask);
        logic [1:0] idx;
        idx = MODE_UP;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/modecount_next.sv
// Combinational transition classifier: which counter modes explain prev -> sample.
module modecount_next #(
    parameter int N = 4
) (
    input  logic [N-1:0] prev_i,
    input  logic [N-1:0] sample_i,
    output logic [3:0]   hit_o,
    output logic         is_hold_o
);

    logic [N-1:0] inc_val;
    logic [N-1:0] dec_val;
    logic [N-1:0] rotl_val;
    logic [N-1:0] rotr_val;

    always_comb begin
        inc_val   = prev_i + N'(1);
        dec_val   = prev_i - N'(1);
        rotl_val  = {prev_i[N-2:0], prev_i[N-1]};
        rotr_val  = {prev_i[0], prev_i[N-1:1]};
        hit_o[0]  = (sample_i == inc_val);
        hit_o[1]  = (sample_i == dec_val);
        hit_o[2]  = (sample_i == rotl_val);
        hit_o[3]  = (sample_i == rotr_val);
        is_hold_o = (sample_i == prev_i);
    end

endmodule

// File: rtl/modecount_monitor.sv
// Passive monitor: identifies the counter mode on a sample stream, locks to it
// and flags samples that break the locked sequence.
module modecount_monitor
    import modecount_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int MAX_MISS = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [N-1:0]     sample,
    output logic [1:0]       mode_out,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int XW = $clog2(MAX_MISS + 1);

    mon_state_e       state_q, state_d;
    logic [N-1:0]     prev_q, prev_d;
    logic [3:0]       mask_q, mask_d;
    logic [MW-1:0]    match_q, match_d;
    logic [XW-1:0]    miss_q, miss_d;
    logic [1:0]       mode_q, mode_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic [3:0]       hit;
    logic             is_hold;
    logic [3:0]       nm;
    logic [MW-1:0]    match_inc;

    modecount_next #(.N(N)) u_next (
        .prev_i    (prev_q),
        .sample_i  (sample),
        .hit_o     (hit),
        .is_hold_o (is_hold)
    );

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        mask_d    = mask_q;
        match_d   = match_q;
        miss_d    = miss_q;
        mode_d    = mode_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        nm        = mask_q & hit;
        match_inc = (match_q >= MW'(LOCK_CNT)) ? MW'(LOCK_CNT) : match_q + MW'(1);

        if (sample_valid) begin
            if (state_q == ST_IDLE) begin
                prev_d  = sample;
                state_d = ST_ACQ;
                mask_d  = 4'hF;
                match_d = '0;
            end else if (!is_hold) begin
                // Hold samples (counter disabled) never touch history or counters.
                prev_d = sample;
                if (state_q == ST_ACQ) begin
                    if (nm != 4'b0000) begin
                        mask_d  = nm;
                        match_d = match_inc;
                        if ($onehot(nm) && (match_inc >= MW'(LOCK_CNT))) begin
                            state_d = ST_TRACK;
                            mode_d  = mask_to_mode(nm);
                            miss_d  = '0;
                        end
                    end else begin
                        mask_d  = 4'hF;
                        match_d = '0;
                    end
                end else if (hit[mode_q]) begin
                    miss_d = '0;
                end else begin
                    err_d  = 1'b1;
                    cnt_d  = (&cnt_q) ? cnt_q : cnt_q + ERR_W'(1);
                    miss_d = miss_q + XW'(1);
                    if (miss_d == XW'(MAX_MISS)) begin
                        state_d = ST_ACQ;
                        mask_d  = 4'hF;
                        match_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            prev_q  <= '0;
            mask_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            mode_q  <= MODE_UP;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            mask_q  <= mask_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mode_out = mode_q;
    assign locked   = (state_q == ST_TRACK);
    assign err      = err_q;
    assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_modecount_monitor.sv
// Scoreboard bench for modecount_monitor with directed sample streams.
module tb_modecount_monitor;
    import modecount_pkg::*;

    localparam int N     = 4;
    localparam int ERR_W = 8;

    typedef struct packed {
        logic             l;
        logic [1:0]       m;
        logic             e;
        logic [ERR_W-1:0] c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sample_valid = 1'b0;
    logic [N-1:0]     sample = '0;
    logic [1:0]       mode_out;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    modecount_monitor #(.N(N), .LOCK_CNT(3), .MAX_MISS(2), .ERR_W(ERR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .mode_out     (mode_out),
        .locked       (locked),
        .err          (err),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [N-1:0] s, input logic l, input logic [1:0] m,
                        input logic e, input logic [ERR_W-1:0] c);
        exp_t x;
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sample       = s;
        x.l = l; x.m = m; x.e = e; x.c = c;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        idle(2);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_mode", int'(mode_out), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: every output update following a valid sample is scored.
    initial begin
        logic v;
        exp_t x;
        forever begin
            @(posedge clk);
            v = sample_valid;
            @(negedge clk);
            if (v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: output with no expectation at %0t", $time);
                end else begin
                    x = exp_q.pop_front();
                    chk("locked", int'(locked), int'(x.l));
                    chk("mode_out", int'(mode_out), int'(x.m));
                    chk("err", int'(err), int'(x.e));
                    chk("err_cnt", int'(err_cnt), int'(x.c));
                end
            end else begin
                chk("err_idle", int'(err), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        chk("init_locked", int'(locked), 0);
        chk("init_mode", int'(mode_out), 0);
        chk("init_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b1;

        // UP stream locks after the fourth sample; idle cycles change nothing
        send(4'd0, 0, MODE_UP, 0, 0);
        send(4'd1, 0, MODE_UP, 0, 0);
        send(4'd2, 0, MODE_UP, 0, 0);
        send(4'd3, 1, MODE_UP, 0, 0);
        idle(3);
        send(4'd4, 1, MODE_UP, 0, 0);
        do_reset();

        // DOWN with wrap, one mismatch, then reset mid-stream discards history
        send(4'b0001, 0, MODE_UP, 0, 0);
        send(4'b0000, 0, MODE_UP, 0, 0);
        send(4'b1111, 0, MODE_UP, 0, 0);
        send(4'b1110, 1, MODE_DOWN, 0, 0);
        send(4'b0011, 1, MODE_DOWN, 1, 1);
        send(4'b0010, 1, MODE_DOWN, 0, 1);
        do_reset();
        send(4'b1001, 0, MODE_UP, 0, 0);
        send(4'b1000, 0, MODE_UP, 0, 0);
        do_reset();

        // ROTL: first transition is ambiguous with UP, then narrows
        send(4'b0001, 0, MODE_UP, 0, 0);
        send(4'b0010, 0, MODE_UP, 0, 0);
        send(4'b0100, 0, MODE_UP, 0, 0);
        send(4'b1000, 1, MODE_ROTL, 0, 0);
        do_reset();

        // Locked UP at 0101, then errors and unlock
        send(4'b0010, 0, MODE_UP, 0, 0);
        send(4'b0011, 0, MODE_UP, 0, 0);
        send(4'b0100, 0, MODE_UP, 0, 0);
        send(4'b0101, 1, MODE_UP, 0, 0);
        send(4'b1001, 1, MODE_UP, 1, 1);
        send(4'b1010, 1, MODE_UP, 0, 1);
        send(4'b0000, 1, MODE_UP, 1, 2);
        send(4'b1111, 0, MODE_UP, 1, 3);
        send(4'b1110, 0, MODE_UP, 0, 3);
        do_reset();

        // Locked ROTR; hold samples must not add misses; ambiguous step stays ROTR
        send(4'b1000, 0, MODE_UP, 0, 0);
        send(4'b0100, 0, MODE_UP, 0, 0);
        send(4'b0010, 0, MODE_UP, 0, 0);
        send(4'b0001, 1, MODE_ROTR, 0, 0);
        send(4'b0101, 1, MODE_ROTR, 1, 1);
        for (int i = 0; i < 5; i++) send(4'b0101, 1, MODE_ROTR, 0, 1);
        send(4'b1010, 1, MODE_ROTR, 0, 1);
        send(4'b1011, 1, MODE_ROTR, 1, 2);
        send(4'b1100, 0, MODE_ROTR, 1, 3);
        idle(3);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/modecount_monitor.md
Name: modecount_monitor

Overview:
- Passive observer for the mode counter's output bus. It watches a stream of N-bit samples and decides which of the four counter modes is producing it: UP, DOWN, ROTL or ROTR.
- Once it has decided, it locks to that mode and then flags any sample that breaks the sequence.
- It is the receive-side counterpart of the mode counter. It is used in self-checking benches and as an on-chip sanity monitor on the count bus.

Parameters:
- N, 4, sample width; N >= 2 is required.
- LOCK_CNT, 3, consecutive matching transitions needed to lock (>= 1).
- MAX_MISS, 2, consecutive mismatches in TRACK that drop the lock (>= 1).
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- sample_valid  in  1  sample is present this cycle.
- sample  in  N  observed count value.
- mode_out  out  2  locked mode: 00 UP, 01 DOWN, 10 ROTL, 11 ROTR.
- locked  out  1  monitor is in the TRACK state.
- err  out  1  one-cycle pulse on a mismatch while locked.
- err_cnt  out  ERR_W  total mismatches since reset; saturates at all-ones.

Behaviour:
- Reset: while rst=0, all state clears asynchronously.
  - State = IDLE; prev, mask, match_cnt and miss_cnt = 0.
  - mode_out=00, locked=0, err=0, err_cnt=0.
  - Reset asserted in the middle of a sequence discards all history.
- Timing: all outputs are registered and update on the clk edge that samples sample_valid=1. There is 1 cycle of latency from a sample to its effect.
- Per-transition match vector hit[3:0], computed from prev:
  - hit[0] = (sample == prev+1 mod 2^N).
  - hit[1] = (sample == prev-1 mod 2^N).
  - hit[2] = (sample == rotate-left-by-1 of prev).
  - hit[3] = (sample == rotate-right-by-1 of prev).
- Hold: sample == prev means the counter is disabled.
  - No state change, no error, match_cnt and miss_cnt unchanged.
  - This check takes priority over hit. The all-0 and all-1 rotation fixed points are covered by it.
- Idle cycles: sample_valid=0 changes nothing.
- IDLE: the first valid sample loads prev. The state moves to ACQ with mask=1111 and match_cnt=0.
- ACQ, on each valid non-hold sample, with nm = mask & hit:
  - nm != 0: mask=nm and match_cnt++ (saturating at LOCK_CNT). If nm is one-hot and the new match_cnt >= LOCK_CNT, go to TRACK: mode_out = index of nm, locked=1, miss_cnt=0.
  - nm == 0: mask=1111 and match_cnt=0. Stay in ACQ, re-seeding from this sample.
  - Ambiguous transitions keep mask multi-hot and still count toward match_cnt. Example: 0101->1010 hits both ROTL and ROTR.
- TRACK, on each valid non-hold sample:
  - hit[mode_out]=1: miss_cnt=0.
  - Otherwise:
    - err pulses for 1 cycle and err_cnt increments, saturating.
    - miss_cnt increments.
    - If the new miss_cnt == MAX_MISS, go to ACQ: locked=0, mask=1111, match_cnt=0. mode_out holds its last value.
- prev is updated to sample on every valid non-hold sample in every state, including mismatches. Resync is therefore relative to the latest value.
- Arithmetic wraps modulo 2^N; there is no overflow flag.

Decomposition:
- Shared package (modecount_pkg) holds:
  - Mode constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_ROTL=2'b10, MODE_ROTR=2'b11.
  - FSM state encoding IDLE/ACQ/TRACK.
  - These constants are reused by the mode counter and its bench.
- One sub-module is natural: modecount_next, a purely combinational block that takes prev and sample and produces hit[3:0] and is_hold, parameterised by N. The top level holds the FSM and counters.

Test Plan (N=4, LOCK_CNT=3, MAX_MISS=2):
- Reset mid-stream: drive rst=0 while locked -> locked=0, mode_out=00, err_cnt=0 immediately. The next sample re-enters IDLE->ACQ.
- UP stream 0,1,2,3 -> locked=1, mode_out=00 the cycle after sample 3. err stays 0.
- DOWN with wrap 0001,0000,1111,1110 -> locked=1, mode_out=01. No error at the 0000->1111 wrap.
- ROTL 0001,0010,0100,1000:
  - 0001->0010 hits UP and ROTL (mask 0101).
  - 0010->0100 narrows mask to ROTL.
  - locked=1, mode_out=10 after the 1000 sample.
- Error and unlock, locked UP at 0101:
  - Inject 1001 -> err pulses once, err_cnt=1, still locked.
  - 1010 -> miss_cnt cleared, no error.
  - Then 0000, 1111 -> 2 errors, err_cnt=3, locked=0.
- Hold and ambiguity, locked ROTR:
  - Repeat 0101 for 5 samples -> no error, state unchanged.
  - Then 1010 (hits both ROTL and ROTR) -> no error, mode_out stays 11.
